chaos_config_loader: RTL
========================

// Module: chaos_config_loader
// PURPOSE
//  Word-to-serial configuration loader for the chaos automaton cell array.
//  Accepts 32-bit words from the housekeeping/LA side via valid/ready and shifts them MSB-first into the array's LUT chain.
//  Captures the bits returned from the chain end into readback words, then pulses a latch strobe once the whole chain is loaded.
//  Sits directly upstream of chaos_array; its readback feeds the firmware-driven full-array load/verify test.
// PARAMETERS
//  XSIZE     20  cell columns in the array
//  YSIZE     20  cell rows in the array
//  LUTBITS   16  configuration bits per cell
//  (derived) CHAIN_LEN = XSIZE*YSIZE*LUTBITS; NWORDS = ceil(CHAIN_LEN/32)
// PORTS
//  clk           in   1   system clock
//  resetn        in   1   asynchronous active-low reset
//  start         in   1   one-cycle pulse: begin a full-chain load (honoured only in IDLE)
//  abort         in   1   one-cycle pulse: terminate the load and return to IDLE
//  wd_valid      in   1   write word valid
//  wd_data       in   32  write word; bit 31 is shifted first
//  wd_ready      out  1   loader accepts wd_data this cycle
//  shift_data    out  1   serial data into the chain head
//  shift_enable  out  1   chain shift enable; one bit moves per asserted cycle
//  shift_in      in   1   serial data returned from the chain tail
//  latch_strobe  out  1   one-cycle pulse: cells transfer shifted data into their LUTs
//  rd_valid      out  1   one-cycle pulse: rd_data holds a completed readback word
//  rd_data       out  32  readback word; first-captured bit lands in bit 31
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse when the load completes (cycle after latch_strobe)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; shift register, capture register and counters cleared.
//  FSM states: IDLE -> WAIT_WORD -> SHIFT -> (WAIT_WORD | LATCH) -> DONE -> IDLE.
//  - IDLE: start=1 clears the bit counter (bitcnt) and word bit index (wbit), then goes to WAIT_WORD. start is ignored in every other state.
//  - WAIT_WORD: wd_ready=1. If wd_valid=1 in the same cycle, load sreg=wd_data, wbit=0, and go to SHIFT. wd_ready is registered-state based (Moore).
//  - SHIFT: shift_enable=1 and shift_data=sreg[31] each cycle. Each cycle also does: sreg<<=1; cap={cap[30:0],shift_in}; bitcnt++; wbit++.
//    - If bitcnt reaches CHAIN_LEN-1 this cycle, go to LATCH.
//    - Otherwise, if wbit reaches 31 this cycle, go to WAIT_WORD.
//  - rd_valid: pulses the cycle after the 32nd captured bit of a word, with rd_data=cap.
//    - Final partial word: rd_valid pulses on entry to LATCH, with rd_data = cap left-justified (unused LSBs=0).
//  - LATCH: latch_strobe=1 for exactly one cycle, then go to DONE.
//  - DONE: done=1 for exactly one cycle, then go to IDLE.
//  - Partial last word: only CHAIN_LEN mod 32 bits (MSBs) of the final word are shifted; the remaining LSBs are discarded.
//  - Latency: 1 cycle from handshake to the first shift_enable; 32 shift cycles per full word; minimum load time CHAIN_LEN + NWORDS + 2 cycles.
//  - abort: wins over all other events in the same cycle, including wd_valid handshake, start and the final shift bit.
//    - Next state is IDLE; latch_strobe, done and rd_valid are never issued for the aborted load; the chain contents are left undefined.
//  - Async reset mid-load: same outcome as abort; outputs drop to 0 immediately.
//  - shift_enable and wd_ready are never high in the same cycle.
//  - Counters: bitcnt width = $clog2(CHAIN_LEN+1); there is no wrap-around, because the FSM leaves SHIFT at CHAIN_LEN-1.
// TESTING
//  (bench params XSIZE=2 YSIZE=2 LUTBITS=16 -> CHAIN_LEN=64, 2 words; chain model = 64-bit shift register)
//  1. start, then words 32'hAB40_0000 and 32'h0000_AB41 -> 64 shift_enable cycles; one latch_strobe; done the following cycle.
//     Model chain holds 64'hAB400000_0000AB41.
//  2. Preload the chain with 64'hFFFF_FFFF_0000_0000, then load all-zero words.
//     -> rd_data=32'hFFFF_FFFF then 32'h0000_0000; chain ends all zero.
//  3. Withhold wd_valid for 10 cycles between words -> shift_enable stays 0 and wd_ready stays 1 throughout the gap; the final chain is unchanged vs. scenario 1.
//  4. Assert abort on shift bit 40 -> IDLE next cycle; busy=0; no latch_strobe, done or 2nd rd_valid.
//     A new start then completes normally.
//  5. Assert resetn=0 mid-SHIFT -> all outputs 0 asynchronously. Pulse start during SHIFT -> no effect on bitcnt.
//  6. LUTBITS=10 (CHAIN_LEN=40): load 32'hFFFF_FFFF, 32'hFF00_0000 -> 40 shifts total.
//     Last rd_valid carries data left-justified with 24 zero LSBs.

Source files
------------

// File: rtl/chaos_config_loader_if.sv
// Word write / readback bus between firmware-facing logic and the chaos config loader.
interface chaos_config_loader_if;
    logic        wd_valid;
    logic [31:0] wd_data;
    logic        wd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    // Firmware side: supplies write words, consumes readback words.
    modport master (
        output wd_valid,
        output wd_data,
        input  wd_ready,
        input  rd_valid,
        input  rd_data
    );

    // Loader side.
    modport slave (
        input  wd_valid,
        input  wd_data,
        output wd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/chaos_config_loader.sv
// Word-to-serial configuration loader for the chaos automaton LUT chain.
// Shifts 32-bit words MSB-first into the chain, captures what falls out of
// the chain tail into readback words, and strobes the latch once the whole
// chain has been filled.
module chaos_config_loader #(
    parameter int unsigned XSIZE   = 20,
    parameter int unsigned YSIZE   = 20,
    parameter int unsigned LUTBITS = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    chaos_config_loader_if.slave   bus,
    output logic                   shift_data,
    output logic                   shift_enable,
    input  logic                   shift_in,
    output logic                   latch_strobe,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CHAIN_LEN = XSIZE * YSIZE * LUTBITS;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WBIT_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   sreg;
    logic [WORD_W-1:0]   cap;
    logic [WORD_W-1:0]   cap_next;
    logic [WORD_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]    bitcnt;
    logic [WBIT_W-1:0]   wbit;
    logic                ready_q;
    logic                rd_valid_q;
    logic                shift_en_q;
    logic                latch_q;
    logic                busy_q;
    logic                done_q;
    logic                last_bit;
    logic                word_end;

    // Capture value including the bit returned from the chain tail this cycle.
    assign cap_next = {cap[WORD_W-2:0], shift_in};
    assign last_bit = (bitcnt == CNT_W'(CHAIN_LEN - 1));
    assign word_end = (wbit == WBIT_W'(WORD_W - 1));

    // Loader FSM with datapath and registered outputs; abort overrides every other event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sreg       <= '0;
            cap        <= '0;
            rd_data_q  <= '0;
            bitcnt     <= '0;
            wbit       <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            shift_en_q <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                sreg       <= '0;
                ready_q    <= 1'b0;
                shift_en_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            bitcnt  <= '0;
                            wbit    <= '0;
                            state   <= WAIT_WORD;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    WAIT_WORD: begin
                        if (bus.wd_valid) begin
                            sreg       <= bus.wd_data;
                            wbit       <= '0;
                            state      <= SHIFT;
                            ready_q    <= 1'b0;
                            shift_en_q <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        sreg   <= {sreg[WORD_W-2:0], 1'b0};
                        cap    <= cap_next;
                        bitcnt <= bitcnt + CNT_W'(1);
                        wbit   <= wbit + WBIT_W'(1);
                        if (last_bit) begin
                            // Unshifted LSBs of the final word are dropped;
                            // the readback is left-justified over the bits captured.
                            state      <= LATCH;
                            sreg       <= '0;
                            shift_en_q <= 1'b0;
                            latch_q    <= 1'b1;
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= cap_next << (WBIT_W'(WORD_W - 1) - wbit);
                        end else if (word_end) begin
                            state      <= WAIT_WORD;
                            shift_en_q <= 1'b0;
                            ready_q    <= 1'b1;
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= cap_next;
                        end
                    end
                    LATCH: begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        ready_q    <= 1'b0;
                        shift_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output drive straight from flops.
    assign bus.wd_ready  = ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign shift_data    = sreg[WORD_W-1];
    assign shift_enable  = shift_en_q;
    assign latch_strobe  = latch_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
